// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and GF(2^8) word helpers
// for the iterative key schedule and round datapath.
package aes_pkg;

    localparam int         NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        SERVE  = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

    // Undo xtime: an odd value can only come from a reduced product.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ XTIME_POLY) >> 1) | 8'h80) : (b >> 1);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four parallel forward S-box lookups, shared by the
// key schedule and the encrypt round path.
module aes_sub_word (
    input  logic [31:0] word,
    output logic [31:0] subbed
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign subbed[8*i +: 8] = SBOX[word[8*i +: 8]];
    end

endmodule

// File: rtl/aes_dec_key_sched.sv
// AES-128 decrypt key schedule: expands forward once to round 10, then
// serves round keys 10..0 by inverting the key step, wrapping via a cached copy.
module aes_dec_key_sched
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [127:0]       key_i,
    input  logic               key_next_i,
    output logic [127:0]       round_key_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               key_valid_o,
    output logic               busy_o
);

    if (NUM_ROUNDS != aes_pkg::NUM_ROUNDS) begin : g_bad_rounds
        $error("aes_dec_key_sched supports AES-128 (10 rounds) only");
    end

    localparam logic [3:0]         LAST_CNT   = 4'(NUM_ROUNDS);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    state_t             state_q, state_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       cache_q, cache_d;
    logic [7:0]         rcon_q, rcon_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] inv_w1, inv_w2, inv_w3;
    logic [31:0] sub_in, sub_out, t_word;
    logic [31:0] fwd_w0, fwd_w1, fwd_w2, fwd_w3;
    logic [127:0] fwd_key, inv_key;

    assign {w0, w1, w2, w3} = key_q;

    // The inverse step recovers the previous w3 first, so the single
    // SubWord unit is fed from it while serving and from w3 while expanding.
    assign inv_w3 = w3 ^ w2;
    assign inv_w2 = w2 ^ w1;
    assign inv_w1 = w1 ^ w0;
    assign sub_in = (state_q == SERVE) ? inv_w3 : w3;

    aes_sub_word u_sub_word (
        .word   (rot_word(sub_in)),
        .subbed (sub_out)
    );

    assign t_word  = sub_out ^ {rcon_q, 24'h0};
    assign fwd_w0  = w0 ^ t_word;
    assign fwd_w1  = w1 ^ fwd_w0;
    assign fwd_w2  = w2 ^ fwd_w1;
    assign fwd_w3  = w3 ^ fwd_w2;
    assign fwd_key = {fwd_w0, fwd_w1, fwd_w2, fwd_w3};
    assign inv_key = {w0 ^ t_word, inv_w1, inv_w2, inv_w3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            cache_q <= '0;
            rcon_q  <= RCON_FIRST;
            cnt_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cache_q <= cache_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // A load restarts expansion from any state and takes priority over key_next_i.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cache_d = cache_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;

        if (load_i) begin
            state_d = EXPAND;
            key_d   = key_i;
            rcon_d  = RCON_FIRST;
            cnt_d   = 4'd1;
            busy_d  = 1'b1;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                EXPAND: begin
                    key_d  = fwd_key;
                    rcon_d = xtime(rcon_q);
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        cache_d = fwd_key;
                        rcon_d  = RCON_LAST;
                        state_d = SERVE;
                        valid_d = 1'b1;
                        round_d = LAST_ROUND;
                        busy_d  = 1'b0;
                    end
                end
                SERVE: begin
                    if (key_next_i) begin
                        if (round_q != '0) begin
                            key_d   = inv_key;
                            round_d = round_q - ROUND_W'(1);
                            rcon_d  = inv_xtime(rcon_q);
                        end else begin
                            key_d   = cache_q;
                            round_d = LAST_ROUND;
                            rcon_d  = RCON_LAST;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign round_key_o = key_q;
    assign round_o     = round_q;
    assign key_valid_o = valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Scoreboard bench for aes_dec_key_sched: a GF(2^8)-derived S-box and forward
// key expansion predict every served round key in reverse order.
module tb_aes_dec_key_sched;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ALT_KEY  = 128'h5a17c3e90b2d4f6681a2b3c4d5e6f708;

    logic         clk;
    logic         rst_n;
    logic         load_i;
    logic [127:0] key_i;
    logic         key_next_i;
    logic [127:0] round_key_o;
    logic [3:0]   round_o;
    logic         key_valid_o;
    logic         busy_o;

    int           total;
    int           bad;
    int           cur_round;
    logic [7:0]   sbox_m [256];
    logic [127:0] rk [11];
    exp_t         exp_q [$];

    aes_dec_key_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load_i),
        .key_i       (key_i),
        .key_next_i  (key_next_i),
        .round_key_o (round_key_o),
        .round_o     (round_o),
        .key_valid_o (key_valid_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_m[x] = s ^ 8'h63;
        end
    endtask

    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [31:0] rw;
        logic [7:0]  rc;
        {w[0], w[1], w[2], w[3]} = k;
        rk[0] = k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rw = {w[3][23:0], w[3][31:24]};
            t  = {sbox_m[rw[31:24]], sbox_m[rw[23:16]], sbox_m[rw[15:8]], sbox_m[rw[7:0]]};
            t  = t ^ {rc, 24'h0};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rk[r] = {w[0], w[1], w[2], w[3]};
            rc = gmul(rc, 8'h02);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic push_next();
        exp_t e;
        cur_round = (cur_round == 0) ? 10 : cur_round - 1;
        e.rnd = 4'(cur_round);
        e.key = rk[cur_round];
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 128'd0, 128'd1);
            return;
        end
        e = exp_q.pop_front();
        checkOutput({tag, "_round"}, 128'(round_o), 128'(e.rnd));
        checkOutput({tag, "_key"}, round_key_o, e.key);
        checkOutput({tag, "_valid"}, 128'(key_valid_o), 128'd1);
    endtask

    // Called at a negedge; returns at the negedge where round 10 is first visible.
    task automatic applyStimulus(input logic [127:0] k, input logic with_next);
        exp_t e;
        int   n;
        int   bc;
        build_model(k);
        exp_q.delete();
        load_i     = 1'b1;
        key_i      = k;
        key_next_i = with_next;
        @(negedge clk);
        load_i     = 1'b0;
        key_next_i = 1'b0;
        checkOutput("load_valid_drop", 128'(key_valid_o), 128'd0);
        cur_round = 10;
        e.rnd = 4'd10;
        e.key = rk[10];
        exp_q.push_back(e);
        n  = 1;
        bc = 0;
        while (!key_valid_o && n < 30) begin
            if (busy_o) bc++;
            @(negedge clk);
            n++;
        end
        checkOutput("expand_latency", 128'(n), 128'd11);
        checkOutput("busy_cycles", 128'(bc), 128'd10);
        checkOutput("busy_low_serve", 128'(busy_o), 128'd0);
        pop_check("r10");
    endtask

    task automatic next_key(input string tag);
        key_next_i = 1'b1;
        push_next();
        @(negedge clk);
        key_next_i = 1'b0;
        pop_check(tag);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        cur_round  = 0;
        rst_n      = 1'b0;
        load_i     = 1'b0;
        key_i      = '0;
        key_next_i = 1'b0;
        build_sbox();

        @(negedge clk);
        checkOutput("rst_key", round_key_o, 128'd0);
        checkOutput("rst_round", 128'(round_o), 128'd0);
        checkOutput("rst_valid", 128'(key_valid_o), 128'd0);
        checkOutput("rst_busy", 128'(busy_o), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(FIPS_KEY, 1'b0);
        checkOutput("fips_r10_literal", round_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        next_key("fips_r9");
        checkOutput("fips_r9_literal", round_key_o, 128'hac7766f319fadc2128d12941575c006e);
        for (int i = 0; i < 9; i++) next_key("fips_walk");
        checkOutput("fips_r0_is_key", round_key_o, FIPS_KEY);

        applyStimulus(SEQ_KEY, 1'b0);
        checkOutput("seq_r10_literal", round_key_o, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        for (int i = 0; i < 10; i++) next_key("seq_walk");
        next_key("seq_wrap");
        checkOutput("seq_wrap_literal", round_key_o, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        checkOutput("seq_wrap_busy", 128'(busy_o), 128'd0);

        key_next_i = 1'b1;
        push_next();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            pop_check("hold_next");
            if (i < 14) push_next();
            else key_next_i = 1'b0;
        end

        for (int i = 0; i < 11 && cur_round != 5; i++) next_key("to_r5");
        checkOutput("at_round5", 128'(round_o), 128'd5);
        applyStimulus(ALT_KEY, 1'b1);
        for (int i = 0; i < 3; i++) next_key("alt_walk");

        build_model(FIPS_KEY);
        load_i = 1'b1;
        key_i  = FIPS_KEY;
        @(negedge clk);
        load_i = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_key", round_key_o, 128'd0);
        checkOutput("async_rst_round", 128'(round_o), 128'd0);
        checkOutput("async_rst_valid", 128'(key_valid_o), 128'd0);
        checkOutput("async_rst_busy", 128'(busy_o), 128'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        key_next_i = 1'b1;
        @(negedge clk);
        key_next_i = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_valid", 128'(key_valid_o), 128'd0);
        checkOutput("post_rst_busy", 128'(busy_o), 128'd0);
        checkOutput("post_rst_round", 128'(round_o), 128'd0);
        checkOutput("post_rst_key", round_key_o, 128'd0);

        applyStimulus(FIPS_KEY, 1'b0);
        next_key("recover_r9");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
